// File: rtl/ysyx_220053_ifid_buffer.sv
// Elastic IF/ID buffer: a small FIFO of {pc, instr, misalign} between fetch and decode.
// Back-pressures fetch through block_o and drops all contents on a redirect flush.
module ysyx_220053_ifid_buffer #(
    parameter int DEPTH  = 2,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_instr,
    output logic                     in_ready,
    output logic                     block_o,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_instr,
    output logic                     out_misalign,
    input  logic                     out_ready,
    output logic [63:0]              fetch_cnt,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]   pc_q     [DEPTH];
    logic [INST_W-1:0] instr_q  [DEPTH];
    logic              mis_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [63:0]      fetch_cnt_q, fetch_cnt_d;

    logic push;
    logic pop;

    // Readiness comes only from registered count, so out_ready never reaches in_ready.
    assign in_ready     = (count_q != FULL_CNT);
    assign block_o      = ~in_ready;
    assign out_valid    = (count_q != '0);
    assign out_pc       = pc_q[rd_ptr_q];
    assign out_instr    = instr_q[rd_ptr_q];
    assign out_misalign = mis_q[rd_ptr_q];
    assign fetch_cnt    = fetch_cnt_q;
    assign occupancy    = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fetch_cnt_d = fetch_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                fetch_cnt_d = fetch_cnt_q + 64'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fetch_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                mis_q[i]   <= 1'b0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fetch_cnt_q <= fetch_cnt_d;
            // Misalignment is latched with the entry so decode never sees fetch's live PC.
            if (push) begin
                pc_q[wr_ptr_q]    <= in_pc;
                instr_q[wr_ptr_q] <= in_instr;
                mis_q[wr_ptr_q]   <= (in_pc[1:0] != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220053_ifid_buffer.sv
// Scoreboard bench for the IF/ID buffer: expected entries are queued when a push is
// driven and compared against the head while decode holds it.
module tb_ysyx_220053_ifid_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [63:0] inPc;
    logic [31:0] inInstr;
    logic        inReady;
    logic        blockO;
    logic        flush;
    logic        outValid;
    logic [63:0] outPc;
    logic [31:0] outInstr;
    logic        outMisalign;
    logic        outReady;
    logic [63:0] fetchCnt;
    logic [1:0]  occupancy;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } entry_t;

    entry_t      sbQ[$];
    logic [63:0] modelFetch;
    int          vectors = 0;
    int          miscompares = 0;

    ysyx_220053_ifid_buffer #(.DEPTH(DEPTH), .PC_W(64), .INST_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_pc(inPc), .in_instr(inInstr),
        .in_ready(inReady), .block_o(blockO), .flush(flush),
        .out_valid(outValid), .out_pc(outPc), .out_instr(outInstr),
        .out_misalign(outMisalign), .out_ready(outReady),
        .fetch_cnt(fetchCnt), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Status checks every cycle, head contents whenever the model holds an entry.
    task automatic checkState(input string tag);
        int n;
        n = sbQ.size();
        checkOutput({tag, ".out_valid"}, 64'(outValid), 64'(n != 0));
        checkOutput({tag, ".in_ready"},  64'(inReady),  64'(n != DEPTH));
        checkOutput({tag, ".block_o"},   64'(blockO),   64'(n == DEPTH));
        checkOutput({tag, ".occupancy"}, 64'(occupancy), 64'(n));
        checkOutput({tag, ".fetch_cnt"}, fetchCnt, modelFetch);
        if (n != 0) begin
            checkOutput({tag, ".out_pc"},       outPc,              sbQ[0].pc);
            checkOutput({tag, ".out_instr"},    64'(outInstr),      64'(sbQ[0].instr));
            checkOutput({tag, ".out_misalign"}, 64'(outMisalign),   64'(sbQ[0].mis));
        end
    endtask

    // One cycle: check state from the last edge, drive inputs, advance the model.
    task automatic applyStimulus(input string tag, input logic v, input logic [63:0] pc,
                                 input logic [31:0] instr, input logic r, input logic f);
        entry_t e;
        logic   doPush;
        logic   doPop;
        @(negedge clk);
        checkState(tag);
        inValid  = v;
        inPc     = pc;
        inInstr  = instr;
        outReady = r;
        flush    = f;
        doPush = v && (sbQ.size() != DEPTH) && !f;
        doPop  = r && (sbQ.size() != 0) && !f;
        if (f) begin
            sbQ.delete();
        end else begin
            if (doPop) void'(sbQ.pop_front());
            if (doPush) begin
                e.pc    = pc;
                e.instr = instr;
                e.mis   = (pc[1:0] != 2'b00);
                sbQ.push_back(e);
                modelFetch = modelFetch + 64'd1;
            end
        end
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        inValid  = 1'b1;
        inPc     = 64'h8000_0040;
        inInstr  = 32'h0000_0013;
        outReady = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        flush    = 1'b0;
        sbQ.delete();
        modelFetch = 64'd0;
        checkOutput({tag, ".out_valid"},    64'(outValid),    64'd0);
        checkOutput({tag, ".out_pc"},       outPc,            64'd0);
        checkOutput({tag, ".out_instr"},    64'(outInstr),    64'd0);
        checkOutput({tag, ".out_misalign"}, 64'(outMisalign), 64'd0);
        checkOutput({tag, ".in_ready"},     64'(inReady),     64'd1);
        checkOutput({tag, ".block_o"},      64'(blockO),      64'd0);
        checkOutput({tag, ".occupancy"},    64'(occupancy),   64'd0);
        checkOutput({tag, ".fetch_cnt"},    fetchCnt,         64'd0);
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; inPc = '0; inInstr = '0;
        outReady = 1'b0; flush = 1'b0; modelFetch = '0;

        applyReset("reset");
        applyStimulus("idle", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);

        // Single instruction passes straight through.
        applyStimulus("single", 1'b1, 64'h8000_0000, 32'h0000_0413, 1'b1, 1'b0);
        applyStimulus("single", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus("single", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("single.fetch_cnt_final", fetchCnt, 64'd1);

        // Fill, reject a third push, then drain in order.
        applyStimulus("fill", 1'b1, 64'h8000_0000, 32'h0000_0513, 1'b0, 1'b0);
        applyStimulus("fill", 1'b1, 64'h8000_0004, 32'h0000_0593, 1'b0, 1'b0);
        applyStimulus("fill", 1'b1, 64'h8000_0008, 32'h0000_0613, 1'b0, 1'b0);
        applyStimulus("fill", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("fill.full_block", 64'(blockO), 64'd1);
        applyStimulus("drain", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus("drain", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus("drain", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

        // Steady stream exercises pointer wrap with simultaneous push and pop.
        for (int i = 0; i < 10; i++) begin
            applyStimulus("stream", 1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0010_0093 + 32'(i), 1'b1, 1'b0);
        end
        applyStimulus("stream", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus("stream", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("stream.fetch_cnt_final", fetchCnt, 64'd13);

        // Flush beats a concurrent push and pop.
        applyStimulus("flush", 1'b1, 64'h8000_0010, 32'h0000_0713, 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 64'h8000_0014, 32'h0000_0793, 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 64'h8000_0100, 32'h0000_0813, 1'b1, 1'b1);
        applyStimulus("flush", 1'b1, 64'h8000_0100, 32'h0000_0813, 1'b0, 1'b0);
        applyStimulus("flush", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus("flush", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);

        // Misaligned PC, then reset while full.
        applyStimulus("misalign", 1'b1, 64'h8000_0002, 32'h0000_0893, 1'b0, 1'b0);
        applyStimulus("misalign", 1'b1, 64'h8000_0008, 32'h0000_0913, 1'b0, 1'b0);
        applyStimulus("misalign", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("misalign.head", 64'(outMisalign), 64'd1);
        applyReset("reset_full");
        applyStimulus("post_reset", 1'b1, 64'h8000_0200, 32'h0000_0993, 1'b0, 1'b0);
        applyStimulus("post_reset", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus("post_reset", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_ifid_buffer.md
Name: ysyx_220053_ifid_buffer

Overview:
- Elastic IF/ID pipeline buffer between the instruction fetch stage and decode.
- Captures each fetched {pc, instr} pair into a small FIFO and presents it to decode with a valid/ready handshake.
- Back-pressures fetch via a stall output that drives fetch's PC-hold (block) input.
- Discards all buffered instructions on a control-flow redirect (flush).

Parameters:
- DEPTH, 2, number of buffer entries; power of two, at least 2.
- PC_W, 64, PC width.
- INST_W, 32, instruction width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_pc  input  PC_W  PC of the presented instruction.
- in_instr  input  INST_W  instruction word.
- in_ready  output  1  buffer can accept an entry this cycle.
- block_o  output  1  equals ~in_ready; fetch holds its PC while high.
- flush  input  1  redirect from execute; discard all contents.
- out_valid  output  1  head entry valid.
- out_pc  output  PC_W  PC of head entry.
- out_instr  output  INST_W  instruction of head entry.
- out_misalign  output  1  head entry pc[1:0] != 2'b00.
- out_ready  input  1  decode consumes head this cycle.
- fetch_cnt  output  64  count of instructions accepted (not flushed at entry).
- occupancy  output  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Storage: DEPTH entries of {pc, instr, misalign}, plus wr_ptr and rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It depends only on registered state, so there is no combinational path from out_ready to in_ready. A full buffer does not accept a push in the same cycle as a pop.
- out_valid = (count != 0). out_pc, out_instr and out_misalign come from the entry at rd_ptr.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. Minimum fetch-to-decode latency is 1 cycle; no bypass.
- Push only: write entry at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (0 < count < DEPTH): both pointers advance, count unchanged.
- Push and pop together with count == 0: not possible, since out_valid = 0.
- flush high: count, wr_ptr and rd_ptr all go to 0 on the next edge.
  - A push or pop in the same cycle has no effect, and fetch_cnt does not increment.
  - Flush has priority over everything except rst.
  - in_ready is unaffected by flush within the cycle (it still reflects count).
- fetch_cnt: increments by 1 on each push; wraps 2^64-1 -> 0.
- out_misalign is computed from in_pc[1:0] at push time and stored with the entry.
- Outputs while out_valid = 0: out_pc, out_instr and out_misalign hold the stale entry at rd_ptr. Decode must ignore them.
- Reset (rst high at an edge, including mid-operation with a full buffer):
  - count=0, wr_ptr=0, rd_ptr=0, fetch_cnt=0, all storage entries cleared to 0.
  - After reset: out_valid=0, out_pc=0, out_instr=0, out_misalign=0, in_ready=1, block_o=0, occupancy=0.
  - rst overrides flush, push and pop.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, block_o=0, out_pc=0, fetch_cnt=0, occupancy=0.
- Push pc=0x80000000, instr=0x00000413 with out_ready=1 -> out_valid=1 one cycle later with matching pc and instr; popped next edge; occupancy returns to 0; fetch_cnt=1.
- out_ready=0, push 0x80000000 then 0x80000004 -> occupancy=2, in_ready=0, block_o=1. A third in_valid is not accepted and fetch_cnt stays 2. Raise out_ready -> pops in order 0x80000000 then 0x80000004.
- Steady stream, in_valid=1 and out_ready=1 every cycle for 10 cycles from 0x80000000 step 4 -> occupancy stays 1 after the first cycle; outputs in order; pointers wrap correctly; fetch_cnt=10.
- Buffer holds 2 entries, assert flush together with in_valid (pc=0x80000100) and out_ready=1 -> next cycle occupancy=0, out_valid=0, fetch_cnt unchanged. A subsequent push of 0x80000100 appears as the head.
- Push pc=0x80000002 -> out_misalign=1. Assert rst while full -> all outputs at reset values next cycle.
